// File: rtl/vga_pkg.sv
// Shared VGA/cursor definitions: screen geometry, cursor sprite encodings and
// the cursor register map.
package vga_pkg;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int CURSOR_SIZE = 16;

    typedef enum logic [1:0] {
        CUR_TRANSP = 2'b00,
        CUR_COL_A  = 2'b01,
        CUR_COL_B  = 2'b10,
        CUR_INVERT = 2'b11
    } cur_code_e;

    localparam logic [4:0] CUR_REG_ROW0  = 5'd0;
    localparam logic [4:0] CUR_REG_COL_A = 5'd16;
    localparam logic [4:0] CUR_REG_COL_B = 5'd17;
    localparam logic [4:0] CUR_REG_CTRL  = 5'd18;

    // Column c of a bitmap row lives in bits [2c+1:2c], column 0 leftmost.
    function automatic logic [1:0] row_code(input logic [31:0] row, input logic [3:0] col);
        return row[{col, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/cursor_bitmap_regs.sv
// 16 x 32-bit cursor bitmap register file: one synchronous write port and one
// combinational read port (a read in the write cycle returns the old row).
module cursor_bitmap_regs import vga_pkg::*; (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  wr_row,
    input  logic [31:0] wr_data,
    input  logic [3:0]  rd_row,
    output logic [31:0] rd_data
);

    logic [31:0] rows_q [CURSOR_SIZE];
    logic [31:0] rows_d [CURSOR_SIZE];

    // Next-state: only the addressed row takes the write data.
    always_comb begin
        for (int i = 0; i < CURSOR_SIZE; i++) begin
            rows_d[i] = (wr_en && (wr_row == 4'(i))) ? wr_data : rows_q[i];
        end
    end

    // Row storage; reset leaves every pixel transparent.
    always_ff @(posedge clock) begin
        for (int i = 0; i < CURSOR_SIZE; i++) begin
            if (reset) begin
                rows_q[i] <= 32'd0;
            end else begin
                rows_q[i] <= rows_d[i];
            end
        end
    end

    assign rd_data = rows_q[rd_row];

endmodule

// File: rtl/mouse_cursor_overlay.sv
// Hardware mouse cursor: overlays a 16x16 2bpp sprite on the VGA pixel stream
// through a fixed two-stage pipeline, with the cursor origin latched per frame.
module mouse_cursor_overlay import vga_pkg::*; #(
    parameter logic [3:0] HOT_X = 4'd0,
    parameter logic [3:0] HOT_Y = 4'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  mouse_x,
    input  logic [9:0]  mouse_y,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [23:0] pix_rgb,
    input  logic [1:0]  pix_sync,
    input  logic        cfg_write,
    input  logic [4:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic        out_valid,
    output logic [23:0] out_rgb,
    output logic [1:0]  out_sync
);

    logic [23:0] col_a_q, col_a_d, col_b_q, col_b_d;
    logic        enable_q, enable_d;
    logic [10:0] org_x_q, org_x_d, org_y_q, org_y_d;
    logic        hit_q, hit_d;
    logic [3:0]  dx_q, dx_d;
    logic [31:0] row_q, row_d;
    logic [23:0] rgb_q, rgb_d;
    logic        valid_q, valid_d;
    logic [1:0]  sync_q, sync_d;
    logic        out_valid_q, out_valid_d;
    logic [23:0] out_rgb_q, out_rgb_d;
    logic [1:0]  out_sync_q, out_sync_d;

    logic [10:0] dx_s, dy_s;
    logic [31:0] bitmap_row_s;
    logic        row_wr_s;
    cur_code_e   code_s;

    assign row_wr_s = cfg_write && (cfg_addr[4] == 1'b0);

    cursor_bitmap_regs u_bitmap (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (row_wr_s),
        .wr_row  (cfg_addr[3:0]),
        .wr_data (cfg_wdata),
        .rd_row  (dy_s[3:0]),
        .rd_data (bitmap_row_s)
    );

    // Colour and enable registers; addresses 19..31 fall through untouched.
    always_comb begin
        col_a_d  = col_a_q;
        col_b_d  = col_b_q;
        enable_d = enable_q;
        case ({cfg_write, cfg_addr})
            {1'b1, CUR_REG_COL_A}: col_a_d  = cfg_wdata[23:0];
            {1'b1, CUR_REG_COL_B}: col_b_d  = cfg_wdata[23:0];
            {1'b1, CUR_REG_CTRL}:  enable_d = cfg_wdata[0];
            default: ;
        endcase
    end

    // Origin latch and stage 1. The new origin is bypassed so a pixel arriving
    // with frame_start is already placed against this frame's cursor position.
    always_comb begin
        org_x_d = frame_start ? ({1'b0, mouse_x} - {7'd0, HOT_X}) : org_x_q;
        org_y_d = frame_start ? ({1'b0, mouse_y} - {7'd0, HOT_Y}) : org_y_q;
        dx_s    = {1'b0, pix_x} - org_x_d;
        dy_s    = {1'b0, pix_y} - org_y_d;
        hit_d   = enable_q && (dx_s[10:4] == 7'd0) && (dy_s[10:4] == 7'd0);
        dx_d    = dx_s[3:0];
        row_d   = hit_d ? bitmap_row_s : 32'd0;
        rgb_d   = pix_rgb;
        valid_d = pix_valid;
        sync_d  = pix_sync;
    end

    // Stage 2: pick the sprite code for this column and mux the output colour.
    always_comb begin
        code_s      = hit_q ? cur_code_e'(row_code(row_q, dx_q)) : CUR_TRANSP;
        out_valid_d = valid_q;
        out_sync_d  = sync_q;
        case (code_s)
            CUR_COL_A:  out_rgb_d = col_a_q;
            CUR_COL_B:  out_rgb_d = col_b_q;
            CUR_INVERT: out_rgb_d = ~rgb_q;
            default:    out_rgb_d = rgb_q;
        endcase
    end

    // All state flops; reset flushes the pipeline and hides the cursor.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_a_q     <= 24'd0;
            col_b_q     <= 24'd0;
            enable_q    <= 1'b0;
            org_x_q     <= 11'd0;
            org_y_q     <= 11'd0;
            hit_q       <= 1'b0;
            dx_q        <= 4'd0;
            row_q       <= 32'd0;
            rgb_q       <= 24'd0;
            valid_q     <= 1'b0;
            sync_q      <= 2'd0;
            out_valid_q <= 1'b0;
            out_rgb_q   <= 24'd0;
            out_sync_q  <= 2'd0;
        end else begin
            col_a_q     <= col_a_d;
            col_b_q     <= col_b_d;
            enable_q    <= enable_d;
            org_x_q     <= org_x_d;
            org_y_q     <= org_y_d;
            hit_q       <= hit_d;
            dx_q        <= dx_d;
            row_q       <= row_d;
            rgb_q       <= rgb_d;
            valid_q     <= valid_d;
            sync_q      <= sync_d;
            out_valid_q <= out_valid_d;
            out_rgb_q   <= out_rgb_d;
            out_sync_q  <= out_sync_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_rgb   = out_rgb_q;
    assign out_sync  = out_sync_q;

endmodule

// File: tb/tb_mouse_cursor_overlay.sv
// Table-driven bench for mouse_cursor_overlay: vectors carry stimulus and the
// expected output, expectations are queued and checked two cycles later.
module tb_mouse_cursor_overlay;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  mouse_x, mouse_y, pix_x, pix_y;
    logic        frame_start, pix_valid, cfg_write;
    logic [23:0] pix_rgb;
    logic [1:0]  pix_sync;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_wdata;

    logic        out_valid0, out_valid1;
    logic [23:0] out_rgb0, out_rgb1;
    logic [1:0]  out_sync0, out_sync1;

    always #5 clock = ~clock;

    mouse_cursor_overlay u_dut (
        .clock(clock), .reset(reset), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .frame_start(frame_start), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .pix_sync(pix_sync), .cfg_write(cfg_write), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .out_valid(out_valid0), .out_rgb(out_rgb0), .out_sync(out_sync0)
    );

    mouse_cursor_overlay #(.HOT_X(4'd8), .HOT_Y(4'd8)) u_hot (
        .clock(clock), .reset(reset), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .frame_start(frame_start), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .pix_sync(pix_sync), .cfg_write(cfg_write), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .out_valid(out_valid1), .out_rgb(out_rgb1), .out_sync(out_sync1)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        fs;
        logic [9:0]  mx, my;
        logic        pv;
        logic [9:0]  px, py;
        logic [23:0] rgb;
        logic [1:0]  sync;
        logic        sel;
        logic        ev;
        logic [23:0] ergb;
        logic [1:0]  esync;
    } vec_t;

    typedef struct {
        logic        sel;
        logic        ev;
        logic [23:0] ergb;
        logic [1:0]  esync;
        int          id;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_id = 0;
    logic [9:0] cur_mx = 10'd0;
    logic [9:0] cur_my = 10'd0;
    logic       cur_sel = 1'b0;

    task automatic add_raw(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                           input logic fs, input logic pv, input logic [9:0] px, input logic [9:0] py,
                           input logic [23:0] rgb, input logic [1:0] sync,
                           input logic ev, input logic [23:0] ergb, input logic [1:0] esync);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.fs = fs;
        v.mx = cur_mx; v.my = cur_my; v.pv = pv; v.px = px; v.py = py;
        v.rgb = rgb; v.sync = sync; v.sel = cur_sel;
        v.ev = ev; v.ergb = ergb; v.esync = esync;
        vecs.push_back(v);
    endtask

    task automatic add_cfg(input logic [4:0] addr, input logic [31:0] data);
        add_raw(1'b1, addr, data, 1'b0, 1'b0, 10'd1000, 10'd1000, 24'd0, 2'd0, 1'b0, 24'd0, 2'd0);
    endtask

    task automatic add_idle();
        add_raw(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 10'd1000, 10'd1000, 24'd0, 2'd0, 1'b0, 24'd0, 2'd0);
    endtask

    task automatic add_fs(input logic [9:0] mx, input logic [9:0] my);
        cur_mx = mx;
        cur_my = my;
        add_raw(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 10'd1000, 10'd1000, 24'd0, 2'd0, 1'b0, 24'd0, 2'd0);
    endtask

    task automatic add_pix(input logic [9:0] px, input logic [9:0] py,
                           input logic [23:0] rgb, input logic [23:0] ergb);
        add_raw(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, px, py, rgb, px[1:0], 1'b1, ergb, px[1:0]);
    endtask

    task automatic check_exp(input exp_t e);
        logic        av;
        logic [23:0] argb;
        logic [1:0]  async_v;
        av      = e.sel ? out_valid1 : out_valid0;
        argb    = e.sel ? out_rgb1   : out_rgb0;
        async_v = e.sel ? out_sync1  : out_sync0;
        n_cmp++;
        if (av !== e.ev || argb !== e.ergb || async_v !== e.esync) begin
            n_bad++;
            $display("FAIL vec%0d dut%0d: got valid=%0b rgb=%06h sync=%0d, want valid=%0b rgb=%06h sync=%0d",
                     e.id, e.sel, av, argb, async_v, e.ev, e.ergb, e.esync);
        end
    endtask

    task automatic check_reset_state(input string name);
        n_cmp++;
        if (out_valid0 !== 1'b0 || out_rgb0 !== 24'd0 || out_sync0 !== 2'd0 ||
            out_valid1 !== 1'b0 || out_rgb1 !== 24'd0 || out_sync1 !== 2'd0) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b/%0b rgb=%06h/%06h sync=%0d/%0d, want all zero",
                     name, out_valid0, out_valid1, out_rgb0, out_rgb1, out_sync0, out_sync1);
        end
    endtask

    // Drive each vector for one cycle; the DUT output after the next edge belongs to the previous vector.
    task automatic apply_vecs();
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            cfg_write = vecs[i].wr;  cfg_addr = vecs[i].addr; cfg_wdata = vecs[i].wdata;
            frame_start = vecs[i].fs; mouse_x = vecs[i].mx;  mouse_y = vecs[i].my;
            pix_valid = vecs[i].pv;  pix_x = vecs[i].px;     pix_y = vecs[i].py;
            pix_rgb = vecs[i].rgb;   pix_sync = vecs[i].sync;
            e.sel = vecs[i].sel; e.ev = vecs[i].ev; e.ergb = vecs[i].ergb; e.esync = vecs[i].esync;
            e.id = vec_id;
            vec_id++;
            exp_q.push_back(e);
            @(posedge clock);
            #1;
            if (exp_q.size() == 2) begin
                check_exp(exp_q.pop_front());
            end
        end
        vecs.delete();
    endtask

    initial begin
        reset = 1'b1;
        cfg_write = 1'b0; cfg_addr = 5'd0; cfg_wdata = 32'd0;
        frame_start = 1'b0; mouse_x = 10'd0; mouse_y = 10'd0;
        pix_valid = 1'b0; pix_x = 10'd1000; pix_y = 10'd1000; pix_rgb = 24'd0; pix_sync = 2'd0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_state("reset_state");
        reset = 1'b0;

        // Cursor disabled: everything passes through.
        add_fs(10'd100, 10'd50);
        for (int x = 95; x <= 120; x++) add_pix(10'(x), 10'd50, {8'(x), 16'h50A5}, {8'(x), 16'h50A5});

        // Row 0 in colour A, cursor enabled at (100,50).
        add_cfg(5'd0, 32'h5555_5555);
        add_cfg(5'd16, 32'h00FF_0000);
        add_cfg(5'd18, 32'h0000_0001);
        add_fs(10'd100, 10'd50);
        for (int x = 98; x <= 117; x++) begin
            logic [23:0] c;
            c = {8'h10, 8'(x), 8'h33};
            add_pix(10'(x), 10'd50, c, (x >= 100 && x <= 115) ? 24'hFF0000 : c);
        end
        add_pix(10'd100, 10'd49, 24'h777777, 24'h777777);

        // Invert code and per-column code selection.
        add_cfg(5'd5, 32'hFFFF_FFFF);
        add_cfg(5'd1, 32'h0000_00E4);
        add_cfg(5'd17, 32'h0000_FF00);
        add_pix(10'd103, 10'd55, 24'h123456, 24'hEDCBA9);
        add_pix(10'd99,  10'd55, 24'h123456, 24'h123456);
        add_pix(10'd116, 10'd55, 24'h123456, 24'h123456);
        add_pix(10'd100, 10'd51, 24'h0A0B0C, 24'h0A0B0C);
        add_pix(10'd101, 10'd51, 24'h0A0B0C, 24'hFF0000);
        add_pix(10'd102, 10'd51, 24'h0A0B0C, 24'h00FF00);
        add_pix(10'd103, 10'd51, 24'h0A0B0C, 24'hF5F4F3);

        // Writes to unmapped addresses change nothing.
        add_cfg(5'd19, 32'h0000_0000);
        add_cfg(5'd31, 32'hFFFF_FFFF);
        add_cfg(5'd24, 32'h0000_0000);
        add_pix(10'd100, 10'd50, 24'h222222, 24'hFF0000);
        add_pix(10'd100, 10'd65, 24'h222222, 24'h222222);

        // Row write in the same cycle as a read of that row: old row first, new row next.
        add_raw(1'b1, 5'd6, 32'h5555_5555, 1'b0, 1'b1, 10'd100, 10'd56, 24'h333333, 2'd0,
                1'b1, 24'h333333, 2'd0);
        add_pix(10'd101, 10'd56, 24'h333333, 24'hFF0000);

        // Mouse moves mid-frame: no effect until frame_start, which the same-cycle pixel sees.
        cur_mx = 10'd300;
        add_pix(10'd300, 10'd50, 24'h444444, 24'h444444);
        add_pix(10'd100, 10'd50, 24'h444444, 24'hFF0000);
        add_raw(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 10'd300, 10'd50, 24'h444444, 2'd0,
                1'b1, 24'hFF0000, 2'd0);
        add_pix(10'd100, 10'd50, 24'h444444, 24'h444444);
        add_pix(10'd315, 10'd50, 24'h444444, 24'hFF0000);
        add_pix(10'd316, 10'd50, 24'h444444, 24'h444444);

        // Hotspot (8,8) at mouse (0,0): negative origin clips, no wrap to the right edge.
        cur_sel = 1'b1;
        add_cfg(5'd8,  32'h5555_5555);
        add_cfg(5'd15, 32'h5555_5555);
        add_fs(10'd0, 10'd0);
        add_pix(10'd0,   10'd0, 24'h565656, 24'hFF0000);
        add_pix(10'd5,   10'd0, 24'h565656, 24'hFF0000);
        add_pix(10'd7,   10'd7, 24'h565656, 24'hFF0000);
        add_pix(10'd8,   10'd0, 24'h565656, 24'h565656);
        add_pix(10'd3,   10'd1, 24'h565656, 24'h565656);
        add_pix(10'd0,   10'd8, 24'h565656, 24'h565656);
        add_pix(10'd632, 10'd0, 24'h565656, 24'h565656);
        add_pix(10'd639, 10'd7, 24'h565656, 24'h565656);

        // Leave a visible cursor pixel in flight before the mid-stream reset.
        cur_sel = 1'b0;
        add_fs(10'd100, 10'd50);
        add_pix(10'd100, 10'd50, 24'h555555, 24'hFF0000);
        apply_vecs();

        pix_valid = 1'b1; pix_x = 10'd101; pix_y = 10'd50; pix_rgb = 24'h555555;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_state("reset_flush");
        exp_q.delete();
        reset = 1'b0;

        // After reset the cursor stays hidden even once enabled: bitmap and colours cleared.
        cur_mx = 10'd100; cur_my = 10'd50;
        add_raw(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 10'd100, 10'd50, 24'h111111, 2'd3,
                1'b1, 24'h111111, 2'd3);
        add_cfg(5'd18, 32'h0000_0001);
        add_pix(10'd100, 10'd50, 24'h111111, 24'h111111);
        add_pix(10'd101, 10'd51, 24'h121212, 24'h121212);
        add_idle();
        add_idle();
        apply_vecs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
